// File: rtl/md_hilo_sched.sv
// md_hilo_sched: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside EX.
// Holds the pipeline while an operation runs, then presents {HI, LO}
// for exactly one cycle so the HI/LO register is written once per op.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting; a valid md_start latches operands and stalls
//   MUL    | product already registered; counting out MUL_LAT cycles
//   DIV    | restoring divide, one quotient bit per cycle, WIDTH cycles
//   DONE   | result_valid pulse, stall released, back to IDLE next
module md_hilo_sched #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             md_start,
   input  logic             mul_or_div,
   input  logic             md_is_sign,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             md_stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy
);

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;        // raw dividend, kept for sign and div-by-zero
   logic [WIDTH-1:0]   b_q, b_d;        // raw divisor, kept for sign and zero test
   logic               sign_q, sign_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   quo_q, quo_d;    // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;    // divisor magnitude
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               start_ok;
   logic               cnt_zero;
   logic [WIDTH:0]     ext_a, ext_b;
   logic [2*WIDTH-1:0] prod_calc;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH+1:0]   div_shift;
   logic               div_ge;
   logic [WIDTH:0]     rem_nx;
   logic [WIDTH-1:0]   quo_nx;
   logic               neg_quo, neg_rem;
   logic               raw_stall;

   assign start_ok = md_start & ~flush;
   assign cnt_zero = (cnt_q == '0);

   // Operand preparation for both units, evaluated on the raw inputs at issue.
   always_comb begin
      ext_a     = {md_is_sign & src_a[WIDTH-1], src_a};
      ext_b     = {md_is_sign & src_b[WIDTH-1], src_b};
      prod_calc = (2*WIDTH)'($signed({{(WIDTH+1){ext_a[WIDTH]}}, ext_a}) *
                             $signed({{(WIDTH+1){ext_b[WIDTH]}}, ext_b}));
      abs_a     = (md_is_sign && src_a[WIDTH-1]) ? -src_a : src_a;
      abs_b     = (md_is_sign && src_b[WIDTH-1]) ? -src_b : src_b;
   end

   // One restoring-divide iteration on the current partial remainder.
   always_comb begin
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_ge    = (div_shift >= {2'b00, dvs_q});
      rem_nx    = div_ge ? (WIDTH+1)'(div_shift - {2'b00, dvs_q})
                         : (WIDTH+1)'(div_shift);
      quo_nx    = {quo_q[WIDTH-2:0], div_ge};
      neg_quo   = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      neg_rem   = sign_q & a_q[WIDTH-1];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush drops any running or finished op back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_ok) state_d = mul_or_div ? S_MUL : S_DIV;
         S_MUL: begin
            if (flush)         state_d = S_IDLE;
            else if (cnt_zero) state_d = S_DONE;
         end
         S_DIV: begin
            if (flush)         state_d = S_IDLE;
            else if (cnt_zero) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; stall is released in the flush cycle and during reset.
   always_comb begin
      raw_stall    = 1'b0;
      result_valid = 1'b0;
      busy         = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:  raw_stall = md_start;
         S_MUL:   raw_stall = 1'b1;
         S_DIV:   raw_stall = 1'b1;
         S_DONE:  result_valid = ~flush;
         default: raw_stall = 1'b0;
      endcase
      md_stall = raw_stall & ~flush & ~rst;
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

   // Datapath next values: latch at issue, iterate, and load HI/LO on the last cycle.
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      sign_d = sign_q;
      prod_d = prod_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               a_d    = src_a;
               b_d    = src_b;
               sign_d = md_is_sign;
               prod_d = prod_calc;
               quo_d  = abs_a;
               rem_d  = '0;
               dvs_d  = abs_b;
               cnt_d  = mul_or_div ? CNT_W'(MUL_LAT - 1) : CNT_W'(WIDTH - 1);
            end
         end
         S_MUL: begin
            if (!flush) begin
               if (cnt_zero) begin
                  hi_d = prod_q[2*WIDTH-1:WIDTH];
                  lo_d = prod_q[WIDTH-1:0];
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_DIV: begin
            if (!flush) begin
               quo_d = quo_nx;
               rem_d = rem_nx;
               if (cnt_zero) begin
                  // Divide by zero reports the raw dividend and an all-ones quotient.
                  if (b_q == '0) begin
                     lo_d = '1;
                     hi_d = a_q;
                  end else begin
                     lo_d = neg_quo ? -quo_nx : quo_nx;
                     hi_d = neg_rem ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sign_q <= 1'b0;
         prod_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         sign_q <= sign_d;
         prod_q <= prod_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_hilo_sched.sv
// Directed bench for md_hilo_sched: inputs change and outputs are sampled
// just after the falling edge, well away from the rising clock edge.
module tb_md_hilo_sched;

   logic        clk;
   logic        rst;
   logic        md_start;
   logic        mul_or_div;
   logic        md_is_sign;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        md_stall;
   logic        result_valid;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   md_hilo_sched #(.WIDTH(32), .MUL_LAT(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .md_start     (md_start),
      .mul_or_div   (mul_or_div),
      .md_is_sign   (md_is_sign),
      .src_a        (src_a),
      .src_b        (src_b),
      .flush        (flush),
      .md_stall     (md_stall),
      .result_valid (result_valid),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, count stall cycles, check the result pulse and that the
   // still-asserted md_start in DONE does not restart the unit.
   task automatic run_op(input string tag, input logic mul, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      @(negedge clk);
      md_start = 1'b1; mul_or_div = mul; md_is_sign = sgn; src_a = a; src_b = b;
      #1;
      n = 0;
      while (md_stall && n < 100) begin
         n++;
         @(negedge clk); #1;
      end
      chk({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
      chk({tag, " result_valid"}, 32'(result_valid), 32'd1);
      chk({tag, " hi"}, hi_out, exp_hi);
      chk({tag, " lo"}, lo_out, exp_lo);
      @(negedge clk); #1;
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
      chk({tag, " valid_after"}, 32'(result_valid), 32'd0);
      md_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; md_start = 1'b0; mul_or_div = 1'b0; md_is_sign = 1'b0;
      src_a = '0; src_b = '0; flush = 1'b0;
      #12;
      chk("reset md_stall", 32'(md_stall), 32'd0);
      chk("reset result_valid", 32'(result_valid), 32'd0);
      chk("reset hi", hi_out, 32'd0);
      chk("reset lo", lo_out, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("MULTU", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 3, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("MULT", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("DIVU 100/7", 1'b0, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("DIV -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("DIV 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
      run_op("DIV min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
      run_op("DIVU by0", 1'b0, 1'b0, 32'h0000_1234, 32'd0, 33, 32'h0000_1234, 32'hFFFF_FFFF);

      // Flush in the tenth divide iteration.
      @(negedge clk);
      md_start = 1'b1; mul_or_div = 1'b0; md_is_sign = 1'b0; src_a = 32'd500; src_b = 32'd9;
      @(negedge clk);
      md_start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush md_stall", 32'(md_stall), 32'd0);
      chk("flush result_valid", 32'(result_valid), 32'd0);
      chk("flush busy_during", 32'(busy), 32'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush busy_next", 32'(busy), 32'd0);
      chk("flush no_valid", 32'(result_valid), 32'd0);
      chk("flush hi_held", hi_out, 32'h0000_1234);

      run_op("DIVU after flush", 1'b0, 1'b0, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

      // Asynchronous reset while the multiplier is running.
      @(negedge clk);
      md_start = 1'b1; mul_or_div = 1'b1; md_is_sign = 1'b1; src_a = 32'd6; src_b = 32'd7;
      @(negedge clk);
      md_start = 1'b0;
      #1;
      chk("midmul busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst md_stall", 32'(md_stall), 32'd0);
      chk("rst result_valid", 32'(result_valid), 32'd0);
      chk("rst hi", hi_out, 32'd0);
      chk("rst lo", lo_out, 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("post rst busy", 32'(busy), 32'd0);
      chk("post rst valid", 32'(result_valid), 32'd0);

      run_op("MULTU after rst", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 3, 32'd1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_hilo_sched.md
Name: md_hilo_sched

Overview:
- Multi-cycle multiply/divide sequencer sitting beside the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU operation from the decoded control bits (md_start, mul_or_div, md_is_sign).
- Runs a fixed-latency multiplier or a 32-iteration restoring divider, and stalls the pipeline while busy.
- Presents the {HI, LO} result for one cycle so the HI/LO register is written exactly once per operation.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- MUL_LAT, 2, cycles spent in MUL state (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- md_start  input  1  EX holds a mult/div op (decoder mdToHilo, valid EX instruction).
- mul_or_div  input  1  1 = multiply, 0 = divide.
- md_is_sign  input  1  1 = signed (MULT/DIV), 0 = unsigned.
- src_a  input  WIDTH  rs value (multiplicand/dividend).
- src_b  input  WIDTH  rt value (multiplier/divisor).
- flush  input  1  exception/pipeline flush; aborts any operation.
- md_stall  output  1  hold IF/ID/EX; combinational.
- result_valid  output  1  one-cycle pulse; hi_out/lo_out are valid to write.
- hi_out  output  WIDTH  HI result (product high / remainder).
- lo_out  output  WIDTH  LO result (product low / quotient).
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (async, any state): state=IDLE, counter=0, all internal regs=0.
  - Reset values: md_stall=0, result_valid=0, hi_out=0, lo_out=0, busy=0.
- IDLE:
  - When md_start=1 and flush=0: latch operands, sign mode and op type.
  - md_stall=1 in this same cycle.
  - Next state is MUL (counter=MUL_LAT-1) or DIV (counter=WIDTH-1).
- MUL:
  - Product = signed or unsigned 2*WIDTH multiply of the latched operands; registered on MUL entry.
  - Decrement counter; when it reaches 0, go to DONE.
  - md_stall=1.
- DIV:
  - Restoring, one quotient bit per cycle, on |dividend| and |divisor| when signed.
  - Remainder register is WIDTH+1 bits; trial subtraction each cycle.
  - Runs WIDTH cycles, then DONE. md_stall=1.
  - Sign fix-up applied entering DONE: quotient negated if operand signs differ; remainder takes the dividend's sign.
- DONE:
  - result_valid=1, md_stall=0, hi_out/lo_out driven from result regs.
  - md_start is ignored here: the same instruction is still in EX.
  - Always returns to IDLE next cycle.
- Stall length:
  - Divide: md_stall high for WIDTH+1 consecutive cycles (33 at default).
  - Multiply: md_stall high for MUL_LAT+1 cycles.
  - Result pulse occurs in the first cycle md_stall is low.
- Divide by zero: still runs the full WIDTH cycles. lo_out = all ones, hi_out = src_a as latched. Signed fix-up is not applied.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- flush:
  - Any non-IDLE state: go to IDLE next cycle, no result_valid.
  - md_stall is forced 0 in the flush cycle (md_stall = raw_stall & ~flush).
  - flush in IDLE with md_start: no start.
  - flush in DONE: result_valid is suppressed.
- hi_out/lo_out hold their last values outside DONE; consumers write only on result_valid.
- busy=1 in MUL, DIV and DONE.

Test Plan:
- MULTU: src_a=0xFFFFFFFF, src_b=2 -> md_stall high 3 cycles, then result_valid with hi=0x00000001, lo=0xFFFFFFFE.
- MULT: src_a=-3 (0xFFFFFFFD), src_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU: 100/7 -> md_stall high exactly 33 cycles, then lo=14, hi=2. md_start held high through DONE must not restart (busy=0 the following cycle).
- DIV signed:
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 -> lo=0xFFFFFFFD, hi=1.
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> after 33 stall cycles, lo=0xFFFFFFFF, hi=0x00001234.
- Abort cases:
  - flush at DIV iteration 10 -> md_stall=0 that cycle, IDLE next, no result_valid.
  - New DIVU issued immediately after -> correct result.
  - rst asserted mid-MUL -> all outputs 0 asynchronously, IDLE after release.
